fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Sequencing controller for the radix-2 butterfly datapath. Runs an in-place, decimation-in-time FFT of NPOINT complex words held in a synchronous dual-port sample RAM. Each cycle it issues one butterfly's read-address pair and twiddle address, and delays the matching write-back addresses by the full RAM-plus-butterfly pipeline depth. It drains the pipeline between stages so that stage s+1 never reads data that stage s has not yet written. Input data is stored in bit-reversed order before `start`; the controller does no reordering.

## Interface
- `LOGN`, 4, log2 of FFT size; legal range 2..10; NPOINT = 2^LOGN.
- `MEM_LAT`, 1, sample RAM read latency in cycles.
- `BFLY_LAT`, 4, butterfly input-to-output latency in cycles (input reg, multiply reg, sum reg, saturate reg).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transform; sampled only in IDLE.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when the transform completes.
- `stage` out LOGN-bit: current stage index, 0..LOGN-1.
- `rd_en` out 1: read strobe, ports A and B.
- `rd_addr_a` out LOGN: read address, top input.
- `rd_addr_b` out LOGN: read address, bottom input.
- `tw_addr` out LOGN-1: twiddle ROM index, presented in the same cycle as `rd_en`.
- `wr_en` out 1: write strobe for the butterfly X/Y outputs.
- `wr_addr_a` out LOGN: write address for X.
- `wr_addr_b` out LOGN: write address for Y.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start`=1, go to RUN and clear `stage` and k (butterfly counter, LOGN-1 bits).
  - `start` in any other state is ignored.
- RUN:
  - `rd_en`=1 every cycle; k increments.
  - When k = NPOINT/2-1, go to DRAIN in the next cycle.
- Address generation, with half = 2^stage:
  - pos = k mod half; grp = k >> stage.
  - `rd_addr_a` = (grp << (stage+1)) | pos.
  - `rd_addr_b` = `rd_addr_a` + half.
  - `tw_addr` = pos << (LOGN-1-stage).
  - All three are registered outputs, valid in the cycle `rd_en`=1.
- Write-back pipeline:
  - Shift register of {valid, addr_a, addr_b}, depth WB_LAT = MEM_LAT + BFLY_LAT.
  - Input is {`rd_en`, `rd_addr_a`, `rd_addr_b`}; output drives `wr_en`, `wr_addr_a`, `wr_addr_b`.
  - Every read produces exactly one write, WB_LAT cycles later.
- DRAIN:
  - `rd_en`=0; a drain counter counts WB_LAT cycles.
  - On the last drain cycle, the final `wr_en` of the stage is asserted.
  - If `stage` = LOGN-1, go to DONE.
  - Otherwise increment `stage`, clear k, and go to RUN.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `busy`=0 in this state.
- Reset (asynchronous, any time):
  - FSM returns to IDLE; `stage`, k, drain counter and every pipeline valid bit are cleared.
  - All outputs go to 0.
  - No `wr_en` is produced after reset, even for reads already issued.

## Timing
- `start` is sampled at edge 0. RUN begins in cycle 1, with the first `rd_en` in cycle 1.
- Each stage occupies NPOINT/2 RUN cycles plus WB_LAT DRAIN cycles.
- The next stage's first read comes one cycle after the previous stage's last write, so there is no read-after-write hazard with a synchronous-write RAM.
- `done` is high in cycle 1 + LOGN·(NPOINT/2 + WB_LAT). With the defaults this is cycle 53.
- `busy` is high in cycles 1..52 with the defaults.
- The first `wr_en` comes in cycle 1+WB_LAT. `wr_en` is never high in IDLE, except that it is always low after DONE.
- The next `start` can be accepted in the cycle after `done` (IDLE).
- `rd_en` and `wr_en` can both be high in the same cycle, during RUN once the pipeline is filled; the RAM must provide separate read and write ports.

## Test plan
- Defaults, pulse `start`:
  - Stage 0, cycles 1..8: (`rd_addr_a`,`rd_addr_b`) = (0,1),(2,3)…(14,15), `tw_addr`=0.
  - `wr_en` in cycles 6..13 with the same pairs.
  - `done` in cycle 53 only.
- Stage 2 (cycles 27..34): pairs (0,4),(1,5),(2,6),(3,7),(8,12)…(11,15); `tw_addr` = 0,2,4,6,0,2,4,6.
- Stage 3: pairs (0,8)…(7,15); `tw_addr` = 0..7; `stage`=3 throughout.
- Hold `start`=1 continuously:
  - A second transform begins only after `done`: `rd_en` rises again in cycle 55.
  - `busy` is never re-triggered mid-run.
- Assert `rst` asynchronously in cycle 20, mid-RUN:
  - All outputs are 0 immediately, including `wr_en`.
  - No write appears afterwards; the FSM stays in IDLE until a new `start`.
- LOGN=2, MEM_LAT=2:
  - Per stage, 2 reads followed by 6 drain cycles.
  - `done` in cycle 1 + 2·(2+6) = 17.
  - Addresses are (0,1),(2,3), then (0,2),(1,3), with `tw_addr` = 0,0 then 0,1.

Source files
------------

// File: rtl/fft_ctrl.sv
// Sequencing controller for an in-place radix-2 DIT FFT: issues butterfly read/twiddle
// addresses each RUN cycle and replays them as write-back addresses after the pipeline delay.
module fft_ctrl #(
  parameter int unsigned LOGN     = 4,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned BFLY_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int unsigned WbLat = MEM_LAT + BFLY_LAT;
  localparam int unsigned DcW   = $clog2(WbLat + 1);
  localparam int unsigned TwW   = LOGN - 1;

  localparam logic [LOGN-2:0] KLast     = '1;
  localparam logic [LOGN-1:0] LastStage = LOGN'(LOGN - 1);
  localparam logic [DcW-1:0]  DcLast    = DcW'(WbLat - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [LOGN-2:0] k_q, k_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [DcW-1:0]  dc_q, dc_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    dc_d    = dc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          k_d     = '0;
          stage_d = '0;
        end
      end
      StRun: begin
        k_d = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = StDrain;
          dc_d    = '0;
        end
      end
      StDrain: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == DcLast) begin
          dc_d = '0;
          if (stage_q == LastStage) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        stage_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address generation from the next k/stage so the outputs come straight off registers.
  logic [LOGN-1:0] kx, half, mask, pos;
  logic [LOGN-1:0] addr_a_d, addr_b_d;
  logic [TwW-1:0]  tw_d;

  always_comb begin
    kx       = LOGN'(k_d);
    half     = LOGN'(1) << stage_d;
    mask     = half - LOGN'(1);
    pos      = kx & mask;
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    if (state_d == StRun) begin
      // Group bits move up one place to open a gap at bit 'stage' for the B partner.
      addr_a_d = ((kx & ~mask) << 1) | pos;
      addr_b_d = addr_a_d | half;
      tw_d     = TwW'(pos << (LastStage - stage_d));
    end
  end

  logic [LOGN-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [TwW-1:0]  tw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      stage_q     <= '0;
      dc_q        <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_q        <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      dc_q        <= dc_d;
      rd_addr_a_q <= addr_a_d;
      rd_addr_b_q <= addr_b_d;
      tw_q        <= tw_d;
    end
  end

  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign stage     = stage_q;
  assign rd_en     = (state_q == StRun);
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_q;

  // Write-back delay line: one entry per RAM-read plus butterfly pipeline stage.
  logic [WbLat-1:0]           vld_q;
  logic [WbLat-1:0][LOGN-1:0] wa_q, wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
    end else begin
      vld_q[0] <= rd_en;
      wa_q[0]  <= rd_addr_a_q;
      wb_q[0]  <= rd_addr_b_q;
      for (int unsigned i = 1; i < WbLat; i++) begin
        vld_q[i] <= vld_q[i-1];
        wa_q[i]  <= wa_q[i-1];
        wb_q[i]  <= wb_q[i-1];
      end
    end
  end

  assign wr_en     = vld_q[WbLat-1];
  assign wr_addr_a = wa_q[WbLat-1];
  assign wr_addr_b = wb_q[WbLat-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: two instances (default and LOGN=2/MEM_LAT=2) compared
// cycle by cycle against a schedule model derived from stage/butterfly arithmetic.
`timescale 1ns/1ps
module tb_fft_ctrl;

  localparam int L1 = 4;
  localparam int M1 = 1;
  localparam int L2 = 2;
  localparam int M2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  logic          busy1, done1, rd1, wr1;
  logic [L1-1:0] st1, ra1, rb1, wa1, wb1;
  logic [L1-2:0] tw1;
  logic          busy2, done2, rd2, wr2;
  logic [L2-1:0] st2, ra2, rb2, wa2, wb2;
  logic [L2-2:0] tw2;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] stage;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] tw;
    logic [15:0] wa;
    logic [15:0] wb;
  } sig_t;

  sig_t o1, o2;
  sig_t zero = '0;
  int total = 0;
  int bad = 0;

  fft_ctrl #(.LOGN(L1), .MEM_LAT(M1), .BFLY_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .stage(st1),
    .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1),
    .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  fft_ctrl #(.LOGN(L2), .MEM_LAT(M2), .BFLY_LAT(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .stage(st2),
    .rd_en(rd2), .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_addr(tw2),
    .wr_en(wr2), .wr_addr_a(wa2), .wr_addr_b(wb2)
  );

  assign o1 = {busy1, done1, rd1, wr1, 16'(st1), 16'(ra1), 16'(rb1), 16'(tw1), 16'(wa1),
               16'(wb1)};
  assign o2 = {busy2, done2, rd2, wr2, 16'(st2), 16'(ra2), 16'(rb2), 16'(tw2), 16'(wa2),
               16'(wb2)};

  always #5 clk = ~clk;

  function automatic int done_cyc(int logn, int mlat);
    return 1 + logn * ((1 << logn) / 2 + mlat + 4);
  endfunction

  // Expected outputs in cycle c of a transform whose start was sampled at edge 0.
  function automatic sig_t model(int logn, int mlat, int c);
    sig_t e;
    int n2, wbl, per, t, s, r, k, half, pos, grp;
    e   = '0;
    n2  = (1 << logn) / 2;
    wbl = mlat + 4;
    per = n2 + wbl;
    if (c < 1) return e;
    t = c - 1;
    s = t / per;
    r = t % per;
    if (s < logn) begin
      e.busy  = 1'b1;
      e.stage = 16'(s);
      half    = 1 << s;
      if (r < n2) begin
        k       = r;
        pos     = k % half;
        grp     = k / half;
        e.rd_en = 1'b1;
        e.ra    = 16'(grp * 2 * half + pos);
        e.rb    = 16'(grp * 2 * half + pos + half);
        e.tw    = 16'(pos * (1 << (logn - 1 - s)));
      end
      if (r >= wbl) begin
        k       = r - wbl;
        pos     = k % half;
        grp     = k / half;
        e.wr_en = 1'b1;
        e.wa    = 16'(grp * 2 * half + pos);
        e.wb    = 16'(grp * 2 * half + pos + half);
      end
    end else if (s == logn && r == 0) begin
      e.done  = 1'b1;
      e.stage = 16'(logn - 1);
    end
    return e;
  endfunction

  // With start held high, a new transform begins the cycle after IDLE is re-entered.
  function automatic int held_cyc(int logn, int mlat, int c);
    int p;
    p = done_cyc(logn, mlat) + 1;
    return ((c - 1) % p) + 1;
  endfunction

  task automatic cmp(string tag, int c, sig_t obs, sig_t exp, bit raw);
    sig_t m;
    m = obs;
    if (!raw) begin
      if (!exp.rd_en) begin m.ra = '0; m.rb = '0; m.tw = '0; end
      if (!exp.wr_en) begin m.wa = '0; m.wb = '0; end
      if (!exp.busy && !exp.done) m.stage = '0;
    end
    total++;
    assert (m === exp) else begin
      bad++;
      $error("FAIL %s c=%0d got busy=%0b done=%0b rd=%0b ra=%0d rb=%0d tw=%0d wr=%0b wa=%0d wb=%0d st=%0d want busy=%0b done=%0b rd=%0b ra=%0d rb=%0d tw=%0d wr=%0b wa=%0d wb=%0d st=%0d",
             tag, c, m.busy, m.done, m.rd_en, m.ra, m.rb, m.tw, m.wr_en, m.wa, m.wb, m.stage,
             exp.busy, exp.done, exp.rd_en, exp.ra, exp.rb, exp.tw, exp.wr_en, exp.wa, exp.wb,
             exp.stage);
    end
  endtask

  // Single start pulse; optionally toggles start randomly while the transform must ignore it.
  task automatic run_pulse(int ncyc, bit rnd);
    @(negedge clk);
    start  = 1'b1;
    start2 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cmp("pulse_d1", c, o1, model(L1, M1, c), 1'b0);
      cmp("pulse_d2", c, o2, model(L2, M2, c), 1'b0);
      start  = (rnd && c <= done_cyc(L1, M1)) ? 1'($urandom_range(0, 1)) : 1'b0;
      start2 = (rnd && c <= done_cyc(L2, M2)) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic run_held(int ncyc);
    @(negedge clk);
    start  = 1'b1;
    start2 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cmp("held_d1", c, o1, model(L1, M1, held_cyc(L1, M1, c)), 1'b0);
      cmp("held_d2", c, o2, model(L2, M2, held_cyc(L2, M2, c)), 1'b0);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for an edge.
  task automatic async_reset(int c);
    #2;
    start  = 1'b0;
    start2 = 1'b0;
    rst    = 1'b1;
    #1;
    cmp("rst_async_d1", c, o1, zero, 1'b1);
    cmp("rst_async_d2", c, o2, zero, 1'b1);
    @(negedge clk);
    cmp("rst_hold_d1", c + 1, o1, zero, 1'b1);
    cmp("rst_hold_d2", c + 1, o2, zero, 1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      cmp("post_rst_d1", i, o1, zero, 1'b1);
      cmp("post_rst_d2", i, o2, zero, 1'b1);
    end
  endtask

  initial begin
    @(negedge clk);
    cmp("reset_d1", 0, o1, zero, 1'b1);
    cmp("reset_d2", 0, o2, zero, 1'b1);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      cmp("idle_d1", 0, o1, zero, 1'b1);
      cmp("idle_d2", 0, o2, zero, 1'b1);
    end
    run_pulse(62, 1'b1);
    run_held(75);
    async_reset(75);
    run_pulse(20, 1'b1);
    async_reset(20);
    run_pulse(60, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
